score_digits: RTL

SCORE_DIGITS -- requirements
Module: score_digits

---
 rtl/score_digits.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/score_digits.sv
// Four-digit score overlay: double-dabble binary-to-BCD converter, vsync-synchronised digit
// update and a 5-stage glyph-ROM pixel pipeline. Define SCORE_LZ_BLANK_EN to blank leading zeros.
module score_digits #(
    parameter logic [10:0] X0     = 11'd40,
    parameter logic [9:0]  Y0     = 10'd20,
    parameter int unsigned WIDTH  = 25,
    parameter int unsigned HEIGHT = 52,
    parameter int unsigned GAP    = 5,
    parameter logic [23:0] COLOR  = 24'hFF_FF_FF
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [13:0] score,
    input  logic        score_valid,
    output logic        busy,
    output logic [13:0] rom_addr,
    input  logic        rom_data,
    output logic [23:0] pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e      state_q, state_d;
    logic        start_q;
    logic [13:0] score_q;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit;
    logic [15:0] adj;

    logic        pending_q;
    logic        vs_prev_q;
    logic        vs_fall;
    logic [3:0]  pend_q [4];
    logic [3:0]  disp_q [4];
    logic [3:0]  lit;

    logic        hit;
    logic [1:0]  idx;
    logic [10:0] lx;
    logic [9:0]  ly;
    logic [31:0] base;
    logic [31:0] hc;
    logic [31:0] vc;

    logic        in_box1_q, in_box2_q, in_box3_q, in_box4_q;
    logic [1:0]  idx1_q;
    logic [10:0] lx1_q;
    logic [9:0]  ly1_q;
    logic [13:0] rom_addr_q;
    logic [23:0] pixel_q;
    logic [4:0]  hs_dly_q, vs_dly_q, bl_dly_q;

    // A one-cycle start register sits ahead of the FSM, so busy spans 1 + 14 + 1 cycles.
    assign busy    = start_q || (state_q != StIdle);
    assign vs_fall = vs_prev_q && !vsync;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            score_q <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            start_q <= score_valid && !busy;
            if (score_valid && !busy) begin
                score_q <= (score > 14'd9999) ? 14'd9999 : score;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        adj     = bcd_q;
        unique case (state_q)
            StIdle: begin
                if (start_q) begin
                    state_d = StShift;
                    bin_d   = score_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                for (int n = 0; n < 4; n++) begin
                    if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = StCommit;
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A commit landing on the vsync edge is shown immediately and never left pending.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            vs_prev_q <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                pend_q[k] <= '0;
                disp_q[k] <= '0;
            end
        end else begin
            vs_prev_q <= vsync;
            if (commit) begin
                pending_q <= !vs_fall;
                for (int k = 0; k < 4; k++) pend_q[k] <= bcd_q[(3-k)*4 +: 4];
            end else if (vs_fall) begin
                pending_q <= 1'b0;
            end
            if (vs_fall && commit) begin
                for (int k = 0; k < 4; k++) disp_q[k] <= bcd_q[(3-k)*4 +: 4];
            end else if (vs_fall && pending_q) begin
                for (int k = 0; k < 4; k++) disp_q[k] <= pend_q[k];
            end
        end
    end

`ifdef SCORE_LZ_BLANK_EN
    always_comb begin
        lit    = 4'b0000;
        lit[0] = (disp_q[0] != 4'd0);
        lit[1] = lit[0] || (disp_q[1] != 4'd0);
        lit[2] = lit[1] || (disp_q[2] != 4'd0);
        lit[3] = 1'b1;
    end
`else
    assign lit = 4'b1111;
`endif

    always_comb begin
        hc   = 32'(hcount);
        vc   = 32'(vcount);
        hit  = 1'b0;
        idx  = 2'd0;
        lx   = '0;
        base = '0;
        ly   = 10'(vc - 32'(Y0));
        if (vc >= 32'(Y0) && vc < 32'(Y0) + HEIGHT) begin
            for (int k = 0; k < 4; k++) begin
                base = 32'(X0) + 32'(k) * (WIDTH + GAP);
                if (hc >= base && hc < base + WIDTH) begin
                    hit = 1'b1;
                    idx = 2'(k);
                    lx  = 11'(hc - base);
                end
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            in_box1_q  <= 1'b0;
            in_box2_q  <= 1'b0;
            in_box3_q  <= 1'b0;
            in_box4_q  <= 1'b0;
            idx1_q     <= '0;
            lx1_q      <= '0;
            ly1_q      <= '0;
            rom_addr_q <= '0;
            pixel_q    <= '0;
            hs_dly_q   <= '1;
            vs_dly_q   <= '1;
            bl_dly_q   <= '1;
        end else begin
            in_box1_q  <= hit;
            idx1_q     <= idx;
            lx1_q      <= lx;
            ly1_q      <= ly;
            // Blanked leading zeros still address the ROM; only the pixel is suppressed.
            in_box2_q  <= in_box1_q && lit[idx1_q];
            rom_addr_q <= in_box1_q ? (14'(disp_q[idx1_q]) * 14'(WIDTH * HEIGHT)
                                       + 14'(ly1_q) * 14'(WIDTH) + 14'(lx1_q)) : 14'd0;
            in_box3_q  <= in_box2_q;
            in_box4_q  <= in_box3_q;
            pixel_q    <= (in_box4_q && rom_data && !bl_dly_q[3]) ? COLOR : 24'd0;
            hs_dly_q   <= {hs_dly_q[3:0], hsync};
            vs_dly_q   <= {vs_dly_q[3:0], vsync};
            bl_dly_q   <= {bl_dly_q[3:0], blank};
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pixel     = pixel_q;
    assign hsync_out = hs_dly_q[4];
    assign vsync_out = vs_dly_q[4];
    assign blank_out = bl_dly_q[4];

endmodule
